// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver FSM states and a parity-check helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Data must be zero-extended to MAX_DATA_BITS so unused bits do not disturb the XOR.
    function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                          input logic                     par_bit,
                                          input parity_e                  mode);
        logic x;
        logic err;
        x = (^data) ^ par_bit;
        case (mode)
            PAR_ODD:  err = ~x;
            PAR_EVEN: err = x;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input with a configurable reset level.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: selectable data width, parity and stop bits, with a
// one-entry ready/valid holding register that reports overrun when a frame is dropped.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter parity_e     PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be at least 4");
    end

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 complete_s;

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_out_q, par_out_d;
    logic                 frm_out_q, frm_out_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (i_Clock),
        .rst_ni(i_Rst_L),
        .d_i   (i_Rx_Serial),
        .q_o   (rx_s)
    );

    // Frame FSM: state register plus baud/bit counters and accumulated frame status.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame FSM next-state: every phase samples at its counter terminal value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        complete_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d     = ST_DATA;
                        bit_d       = 4'd0;
                        par_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = parity_error(MAX_DATA_BITS'(shift_q), rx_s, PARITY);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    frame_err_d = frame_err_q | ~rx_s;
                    if (bit_q == STOP_LAST) begin
                        bit_d      = 4'd0;
                        complete_s = 1'b1;
                        state_d    = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Holding register: a completed frame loads only if the slot is free or being drained.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        par_out_d = par_out_q;
        frm_out_d = frm_out_q;
        ovr_d     = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        if (complete_s) begin
            if (!valid_q || i_Rx_Ready) begin
                valid_d   = 1'b1;
                data_d    = shift_q;
                par_out_d = par_err_q;
                frm_out_d = frame_err_d;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_Rx_Ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            par_out_q <= 1'b0;
            frm_out_q <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            par_out_q <= par_out_d;
            frm_out_q <= frm_out_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_Rx_Valid   = valid_q;
    assign o_Rx_Data    = data_q;
    assign o_Parity_Err = par_out_q;
    assign o_Frame_Err  = frm_out_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7N2 instances driven with hand-built frames.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB = 87;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;

    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic [7:0] data_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;
    logic [7:0] data_b;
    logic       valid_c, perr_c, ferr_c, ovr_c, busy_c;
    logic [6:0] data_c;

    int tests_run = 0;
    int fails     = 0;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0, ocnt_a = 0;

    always #50 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut_a (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_a), .i_Rx_Ready(rdy_a),
        .o_Rx_Valid(valid_a), .o_Rx_Data(data_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Overrun(ovr_a), .o_Busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_dut_b (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_b), .i_Rx_Ready(rdy_b),
        .o_Rx_Valid(valid_b), .o_Rx_Data(data_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Overrun(ovr_b), .o_Busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) u_dut_c (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_c), .i_Rx_Ready(rdy_c),
        .o_Rx_Valid(valid_c), .o_Rx_Data(data_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_Overrun(ovr_c), .o_Busy(busy_c));

    // Count cycles with valid / overrun high so tests can measure pulses as deltas.
    always @(posedge clk) begin
        if (valid_a) vcnt_a <= vcnt_a + 1;
        if (valid_b) vcnt_b <= vcnt_b + 1;
        if (valid_c) vcnt_c <= vcnt_c + 1;
        if (ovr_a)   ocnt_a <= ocnt_a + 1;
    end

    task automatic set_line(input int ch, input logic v);
        case (ch)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Bits go out LSB first, each held for one bit time; the line keeps the last bit.
    task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(ch, bits[i]);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({valid_a, perr_a, ferr_a, ovr_a, busy_a} !== 5'b0) begin
            fails++; $display("FAIL reset_flags_a: got %b expected 00000", {valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        tests_run++;
        if (data_a !== 8'h00) begin
            fails++; $display("FAIL reset_data_a: got %h expected 00", data_a);
        end
        tests_run++;
        if ({valid_b, perr_b, ferr_b, ovr_b, busy_b} !== 5'b0) begin
            fails++; $display("FAIL reset_flags_b: got %b expected 00000", {valid_b, perr_b, ferr_b, ovr_b, busy_b});
        end
        tests_run++;
        if ({valid_c, perr_c, ferr_c, ovr_c, busy_c, data_c} !== 12'h000) begin
            fails++; $display("FAIL reset_c: got %h expected 000", {valid_c, perr_c, ferr_c, ovr_c, busy_c, data_c});
        end
    endtask

    task automatic test_8n1();
        int v0;
        v0 = vcnt_a;
        rdy_a = 1'b1;
        send_bits(0, {6'b0, 1'b1, 8'h3F, 1'b0}, 10);
        repeat (5) @(negedge clk);
        tests_run++;
        if (vcnt_a - v0 !== 1) begin
            fails++; $display("FAIL 8n1_valid_cycles: got %0d expected 1", vcnt_a - v0);
        end
        tests_run++;
        if (data_a !== 8'h3F) begin
            fails++; $display("FAIL 8n1_data: got %h expected 3f", data_a);
        end
        tests_run++;
        if ({perr_a, ferr_a, valid_a, busy_a} !== 4'b0000) begin
            fails++; $display("FAIL 8n1_flags: got %b expected 0000", {perr_a, ferr_a, valid_a, busy_a});
        end
    endtask

    task automatic test_parity_even();
        int v0;
        v0 = vcnt_b;
        send_bits(1, {4'b0, 1'b1, 1'b0, 8'hAB, 1'b0}, 11);
        repeat (5) @(negedge clk);
        tests_run++;
        if (data_b !== 8'hAB || vcnt_b - v0 !== 1) begin
            fails++; $display("FAIL par_bad_data: got %h/%0d expected ab/1", data_b, vcnt_b - v0);
        end
        tests_run++;
        if ({perr_b, ferr_b} !== 2'b10) begin
            fails++; $display("FAIL par_bad_flags: got %b expected 10", {perr_b, ferr_b});
        end
        v0 = vcnt_b;
        send_bits(1, {4'b0, 1'b1, 1'b1, 8'hAB, 1'b0}, 11);
        repeat (5) @(negedge clk);
        tests_run++;
        if (data_b !== 8'hAB || vcnt_b - v0 !== 1) begin
            fails++; $display("FAIL par_good_data: got %h/%0d expected ab/1", data_b, vcnt_b - v0);
        end
        tests_run++;
        if ({perr_b, ferr_b} !== 2'b00) begin
            fails++; $display("FAIL par_good_flags: got %b expected 00", {perr_b, ferr_b});
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcnt_a;
        set_line(0, 1'b0);
        repeat (10) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b1) begin
            fails++; $display("FAIL glitch_busy_during: got %b expected 1", busy_a);
        end
        repeat (10) @(negedge clk);
        set_line(0, 1'b1);
        repeat (80) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || vcnt_a - v0 !== 0) begin
            fails++; $display("FAIL glitch_after: got busy=%b valid_cycles=%0d expected 0/0", busy_a, vcnt_a - v0);
        end
    endtask

    task automatic test_frame_err();
        int v0;
        v0 = vcnt_a;
        send_bits(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
        repeat (3 * CPB) @(negedge clk);
        tests_run++;
        if (vcnt_a - v0 !== 1 || data_a !== 8'h55) begin
            fails++; $display("FAIL frame_err_data: got %h/%0d expected 55/1", data_a, vcnt_a - v0);
        end
        tests_run++;
        if ({ferr_a, perr_a, busy_a} !== 3'b101) begin
            fails++; $display("FAIL frame_err_flags: got %b expected 101", {ferr_a, perr_a, busy_a});
        end
        set_line(0, 1'b1);
        repeat (20) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || vcnt_a - v0 !== 1) begin
            fails++; $display("FAIL frame_err_release: got busy=%b valid_cycles=%0d expected 0/1", busy_a, vcnt_a - v0);
        end
    endtask

    task automatic test_back_to_back_overrun();
        int o0;
        o0 = ocnt_a;
        rdy_a = 1'b0;
        send_bits(0, {6'b0, 1'b1, 8'h12, 1'b0}, 10);
        send_bits(0, {6'b0, 1'b1, 8'h34, 1'b0}, 10);
        repeat (5) @(negedge clk);
        tests_run++;
        if (valid_a !== 1'b1 || data_a !== 8'h12 || ferr_a !== 1'b0) begin
            fails++; $display("FAIL overrun_held: got v=%b d=%h fe=%b expected 1/12/0", valid_a, data_a, ferr_a);
        end
        tests_run++;
        if (ocnt_a - o0 !== 1) begin
            fails++; $display("FAIL overrun_pulses: got %0d expected 1", ocnt_a - o0);
        end
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        @(negedge clk);
        tests_run++;
        if (valid_a !== 1'b0 || data_a !== 8'h12) begin
            fails++; $display("FAIL overrun_drain: got v=%b d=%h expected 0/12", valid_a, data_a);
        end
        rdy_a = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        v0 = vcnt_c;
        send_bits(2, {6'b0, 2'b11, 7'h2A, 1'b0}, 10);
        repeat (5) @(negedge clk);
        tests_run++;
        if (data_c !== 7'h2A || vcnt_c - v0 !== 1) begin
            fails++; $display("FAIL c_first_frame: got %h/%0d expected 2a/1", data_c, vcnt_c - v0);
        end
        v0 = vcnt_c;
        send_bits(2, {6'b0, 2'b11, 7'h41, 1'b0}, 3);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({valid_c, busy_c, ovr_c, perr_c, ferr_c, data_c} !== 12'h000) begin
            fails++; $display("FAIL c_in_reset: got %h expected 000", {valid_c, busy_c, ovr_c, perr_c, ferr_c, data_c});
        end
        tests_run++;
        if (data_a !== 8'h00 || data_b !== 8'h00) begin
            fails++; $display("FAIL others_in_reset: got %h/%h expected 00/00", data_a, data_b);
        end
        set_line(2, 1'b1);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        tests_run++;
        if (vcnt_c - v0 !== 0 || busy_c !== 1'b0) begin
            fails++; $display("FAIL c_after_reset: got valid_cycles=%0d busy=%b expected 0/0", vcnt_c - v0, busy_c);
        end
        send_bits(2, {6'b0, 2'b11, 7'h41, 1'b0}, 10);
        repeat (5) @(negedge clk);
        tests_run++;
        if (data_c !== 7'h41 || vcnt_c - v0 !== 1 || {perr_c, ferr_c} !== 2'b00) begin
            fails++; $display("FAIL c_recover: got %h/%0d/%b expected 41/1/00", data_c, vcnt_c - v0, {perr_c, ferr_c});
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_even();
        test_glitch();
        test_frame_err();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
